lvc161_timer_ctrl: RTL and testbench

Sequencer that drives an external 74LVC161-compatible 4-bit synchronous counter as a programmable period timer. It owns the counter's PE, CEP, CET and D inputs, observes Q and TC, and turns the counter into a one-shot or auto-reloading modulo-N timer (N = 1..16). It reports period completions and keeps a saturating period tally. It sits beside the counter on the same CP clock domain.

---
 rtl/lvc161_timer_ctrl.sv | 85 ++++++++
 tb/tb_lvc161_timer_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lvc161_timer_ctrl.sv
// lvc161_timer_ctrl: sequencer turning an external 74LVC161 counter into a modulo-N period timer
//   CP, CR            clock, asynchronous active-high reset
//   cfg_valid/ready   config handshake (accepted only in IDLE); cfg_n (0 = 16), cfg_reload
//   start, stop       run/resume and pause/abort requests (stop wins)
//   Q, TC             counter observation
//   PE, CEP, CET, D   counter control (PE active-low)
//   busy, period_done, period_cnt, load_err   status
module lvc161_timer_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             CP,
    input  logic             CR,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [3:0]       cfg_n,
    input  logic             cfg_reload,
    input  logic             start,
    input  logic             stop,
    input  logic [3:0]       Q,
    input  logic             TC,
    output logic             PE,
    output logic             CEP,
    output logic             CET,
    output logic [3:0]       D,
    output logic             busy,
    output logic             period_done,
    output logic [CNT_W-1:0] period_cnt,
    output logic             load_err
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, PAUSE} state_t;
    state_t state;
    logic   reload;
    logic   first_run;
    assign cfg_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign CEP       = state == RUN;
    assign CET       = state == RUN;
    // TC forces a parallel load so the counter restarts at D instead of wrapping to 0
    assign PE        = ~((state == LOAD) | ((state == RUN) & TC));
    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state       <= IDLE;
            D           <= 4'd0;
            reload      <= 1'b0;
            first_run   <= 1'b0;
            period_done <= 1'b0;
            period_cnt  <= '0;
            load_err    <= 1'b0;
        end else begin
            period_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        // counting from 16-N up to 15 takes exactly N cycles
                        D      <= ~cfg_n + 4'd1;
                        reload <= cfg_reload;
                    end
                    if (start & ~stop) begin
                        state      <= LOAD;
                        period_cnt <= '0;
                    end
                end
                LOAD: begin
                    state     <= RUN;
                    first_run <= 1'b1;
                end
                RUN: begin
                    first_run <= 1'b0;
                    if (first_run && Q != D)
                        load_err <= 1'b1;
                    if (TC) begin
                        period_done <= 1'b1;
                        if (period_cnt != '1)
                            period_cnt <= period_cnt + CNT_W'(1);
                        state <= !reload ? IDLE : stop ? PAUSE : RUN;
                    end else if (stop) begin
                        state <= PAUSE;
                    end
                end
                PAUSE: state <= stop ? IDLE : start ? RUN : PAUSE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lvc161_timer_ctrl.sv
// tb_lvc161_timer_ctrl: table-driven bench with 74LVC161 models and a period_done scoreboard
module tb_lvc161_timer_ctrl;
    logic       CP = 1'b0, CR = 1'b1;
    logic       cfg_valid = 1'b0, cfg_reload = 1'b0, start = 1'b0, stop = 1'b0;
    logic [3:0] cfg_n = 4'd0;
    logic       cfg_ready1, pe1, cep1, cet1, busy1, pd1, le1;
    logic       cfg_ready2, pe2, cep2, cet2, busy2, pd2, le2;
    logic [3:0] d1, d2;
    logic [7:0] pc1;
    logic [1:0] pc2;
    logic [3:0] q1 = 4'd0, q2 = 4'd0;
    logic       tc1, tc2;
    logic       ignore_pe = 1'b0;
    int         checks = 0, failures = 0, cyc = 0;
    int         sb[$];

    typedef struct {
        logic [3:0] n;
        logic       rl;
        int         w;
        logic [3:0] d;
        int         cnt;
        int         cnt2;
    } vec_t;
    vec_t vt[7];

    always #5 CP = ~CP;

    lvc161_timer_ctrl #(.CNT_W(8)) dut1 (
        .CP(CP), .CR(CR), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready1), .cfg_n(cfg_n),
        .cfg_reload(cfg_reload), .start(start), .stop(stop), .Q(q1), .TC(tc1), .PE(pe1),
        .CEP(cep1), .CET(cet1), .D(d1), .busy(busy1), .period_done(pd1),
        .period_cnt(pc1), .load_err(le1));

    lvc161_timer_ctrl #(.CNT_W(2)) dut2 (
        .CP(CP), .CR(CR), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2), .cfg_n(cfg_n),
        .cfg_reload(cfg_reload), .start(start), .stop(stop), .Q(q2), .TC(tc2), .PE(pe2),
        .CEP(cep2), .CET(cet2), .D(d2), .busy(busy2), .period_done(pd2),
        .period_cnt(pc2), .load_err(le2));

    assign tc1 = (q1 == 4'hF) && cet1;
    assign tc2 = (q2 == 4'hF) && cet2;

    // 74LVC161 models; counter 1 can be made to miss the LOAD-state parallel load
    always_ff @(posedge CP) begin
        if (!pe1 && !(ignore_pe && !cet1))
            q1 <= d1;
        else if (cep1 && cet1)
            q1 <= q1 + 4'd1;
    end
    always_ff @(posedge CP) begin
        if (!pe2)
            q2 <= d2;
        else if (cep2 && cet2)
            q2 <= q2 + 4'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        bit exp;
        @(posedge CP);
        cyc++;
        @(negedge CP);
        exp = sb.size() > 0 && sb[0] == cyc;
        if (exp)
            void'(sb.pop_front());
        if (pd1 || exp)
            chk("period_done", 32'(pd1), 32'(exp));
        if (pd2 || exp)
            chk("period_done_w2", 32'(pd2), 32'(exp));
    endtask

    initial begin
        int r;
        vt[0] = '{4'd5,  1'b0, 10, 4'd11, 1, 1};
        vt[1] = '{4'd0,  1'b1, 40, 4'd0,  2, 2};
        vt[2] = '{4'd1,  1'b1, 8,  4'd15, 8, 3};
        vt[3] = '{4'd3,  1'b1, 10, 4'd13, 3, 3};
        vt[4] = '{4'd8,  1'b0, 12, 4'd8,  1, 1};
        vt[5] = '{4'd15, 1'b1, 20, 4'd1,  1, 1};
        vt[6] = '{4'd2,  1'b1, 9,  4'd14, 4, 3};

        @(negedge CP);
        chk("rst_pe", 32'(pe1), 1);
        chk("rst_cep", 32'(cep1), 0);
        chk("rst_cet", 32'(cet1), 0);
        chk("rst_d", 32'(d1), 0);
        chk("rst_ready", 32'(cfg_ready1), 1);
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_done", 32'(pd1), 0);
        chk("rst_cnt", 32'(pc1), 0);
        chk("rst_err", 32'(le1), 0);
        CR = 1'b0;

        for (int v = 0; v < 7; v++) begin
            int nn, c0, t;
            cfg_valid = 1'b1; cfg_n = vt[v].n; cfg_reload = vt[v].rl; start = 1'b1;
            tick;
            c0 = cyc;
            cfg_valid = 1'b0; start = 1'b0;
            chk("load_pe", 32'(pe1), 0);
            chk("load_ready", 32'(cfg_ready1), 0);
            chk("cfg_d", 32'(d1), 32'(vt[v].d));
            nn = vt[v].n == 4'd0 ? 16 : int'(vt[v].n);
            t = c0 + nn + 1;
            while (t <= c0 + vt[v].w + 1) begin
                sb.push_back(t);
                if (!vt[v].rl)
                    break;
                t += nn;
            end
            for (int i = 1; i <= vt[v].w; i++) begin
                tick;
                if (i == 1) begin
                    chk("first_run_q", 32'(q1), 32'(vt[v].d));
                    chk("first_run_cep", 32'(cep1), 1);
                end
            end
            stop = 1'b1;
            tick;
            tick;
            stop = 1'b0;
            tick;
            chk("end_busy", 32'(busy1), 0);
            chk("end_busy_w2", 32'(busy2), 0);
            chk("period_cnt", 32'(pc1), 32'(vt[v].cnt));
            chk("period_cnt_w2", 32'(pc2), 32'(vt[v].cnt2));
            chk("missed_pulses", 32'(sb.size()), 0);
            chk("load_err", 32'(le1), 0);
            if (!vt[v].rl)
                chk("oneshot_q", 32'(q1), 32'(vt[v].d));
            sb.delete();
        end

        cfg_valid = 1'b1; cfg_n = 4'd4; cfg_reload = 1'b1;
        tick;
        cfg_valid = 1'b0;
        chk("pause_cfg_d", 32'(d1), 12);
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        stop = 1'b1;
        tick;
        stop = 1'b0;
        chk("pause_q", 32'(q1), 14);
        chk("pause_busy", 32'(busy1), 1);
        chk("pause_cep", 32'(cep1), 0);
        chk("pause_pe", 32'(pe1), 1);
        cfg_valid = 1'b1; cfg_n = 4'd7;
        repeat (7) tick;
        chk("pause_hold_q", 32'(q1), 14);
        chk("busy_cfg_ignored", 32'(d1), 12);
        chk("busy_ready", 32'(cfg_ready1), 0);
        cfg_valid = 1'b0;
        start = 1'b1;
        tick;
        r = cyc;
        start = 1'b0;
        sb.push_back(r + 2);
        sb.push_back(r + 6);
        tick;
        chk("resume_tc_q", 32'(q1), 15);
        chk("resume_tc_pe", 32'(pe1), 0);
        repeat (4) tick;
        chk("stop_tc_q", 32'(q1), 15);
        chk("stop_tc_tc", 32'(tc1), 1);
        chk("stop_tc_pe", 32'(pe1), 0);
        stop = 1'b1; start = 1'b1;
        tick;
        chk("stop_tc_reload_q", 32'(q1), 12);
        chk("stop_tc_paused", 32'(busy1), 1);
        chk("stop_tc_cep", 32'(cep1), 0);
        tick;
        chk("abort_busy", 32'(busy1), 0);
        tick;
        chk("idle_stop_wins", 32'(busy1), 0);
        stop = 1'b0; start = 1'b0;
        chk("pause_cnt", 32'(pc1), 2);
        chk("pause_sb_empty", 32'(sb.size()), 0);

        ignore_pe = 1'b1;
        cfg_valid = 1'b1; cfg_n = 4'd6; start = 1'b1;
        tick;
        cfg_valid = 1'b0; start = 1'b0;
        tick;
        tick;
        chk("load_err_set", 32'(le1), 1);
        chk("load_err_clean_w2", 32'(le2), 0);
        tick;
        chk("load_err_sticky", 32'(le1), 1);
        CR = 1'b1;
        #1;
        chk("cr_busy", 32'(busy1), 0);
        chk("cr_pe", 32'(pe1), 1);
        chk("cr_cep", 32'(cep1), 0);
        chk("cr_cet", 32'(cet1), 0);
        chk("cr_d", 32'(d1), 0);
        chk("cr_ready", 32'(cfg_ready1), 1);
        chk("cr_cnt", 32'(pc1), 0);
        chk("cr_err", 32'(le1), 0);
        chk("cr_done", 32'(pd1), 0);
        @(negedge CP);
        CR = 1'b0;
        ignore_pe = 1'b0;
        tick;
        chk("post_cr_busy", 32'(busy1), 0);
        chk("final_sb_empty", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
